masked_share_decoder: RTL and testbench
=======================================

Name: masked_share_decoder

Overview:
- Receiving end of the 2-share Boolean-masked datapath: accepts share pairs of a masked sum word and a masked carry bit, and recombines them into plain values.
- Sits at the boundary where masked arithmetic results are released as plaintext.
- Shares pass through a register barrier before any XOR recombination, so glitches cannot combine shares early.
- Valid/ready handshake on both sides; one word per cycle throughput.

Parameters:
- WIDTH, 8, bits per sum share.
- CNT_W, 16, width of the decoded-word counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input share set valid.
- in_ready  out  1  decoder can accept the input share set this cycle.
- in_s0  in  WIDTH  sum share 0.
- in_s1  in  WIDTH  sum share 1.
- in_c0  in  1  carry share 0.
- in_c1  in  1  carry share 1.
- out_valid  out  1  recombined result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  unmasked sum, equal to s0 XOR s1.
- out_carry  out  1  unmasked carry, equal to c0 XOR c1.
- out_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (sync, active-high, overrides everything that cycle):
  - All share registers, out_sum, out_carry, out_count = 0.
  - Both stage valid flags = 0, so out_valid = 0 and in_ready = 1 the cycle after reset.
- Stage 1 (share barrier):
  - Holds s0, s1, c0, c1 in four separate registers plus valid flag v1.
  - No logic combines shares before this register.
- Stage 2 (recombine):
  - Registers out_sum = s0_q ^ s1_q and out_carry = c0_q ^ c1_q.
  - Valid flag v2 drives out_valid.
- Advance rules:
  - adv2 = v1 && (!v2 || out_ready).
  - in_ready = !v1 || adv2; this is combinational, with no dependency on in_valid.
  - Input accept = in_valid && in_ready, which loads stage 1 and sets v1.
  - If adv2 and no accept: v1 clears.
  - If accept and adv2 in the same cycle: stage 1 reloads and v1 stays 1.
  - v2 sets on adv2; v2 clears on out_ready && !adv2.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no backpressure.
- Throughput: one word per cycle while out_ready = 1.
- Output stability: while out_valid && !out_ready, out_sum and out_carry hold.
- Backpressure capacity:
  - Two words buffered (stage 1 + stage 2).
  - in_ready deasserts only when both stages are full and out_ready = 0.
  - No word is dropped, duplicated or reordered.
- Share hygiene:
  - Stage 1 share registers load only on accept and otherwise hold.
  - Never combine s0 with s1, or c0 with c1, except in the stage-2 XOR.
- Counter:
  - out_count increments by 1 on each out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight words are discarded without ever asserting out_valid, and the counter returns to 0.
- Simultaneous in_valid and out_ready with both stages full: pop and push in the same cycle. in_ready = 1 because adv2 = 1.
- Input shares are don't-care while in_valid = 0. Stage 1 must not load them.

Test Plan:
- Single word: in_s0=0xA5, in_s1=0x3C, in_c0=1, in_c1=0, out_ready=1 -> 2 cycles later out_valid=1, out_sum=0x99, out_carry=1, out_count 0->1.
- Carry truth table, four back-to-back words (c0,c1)=(0,0),(0,1),(1,0),(1,1) -> out_carry sequence 0,1,1,0 on consecutive cycles; in_ready stays 1.
- Backpressure: stream 0x01..0x05 with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; out_sum holds 0x01; on release outputs are exactly 0x01..0x05 in order, none lost.
- Counter wrap, CNT_W=4: 17 handshakes -> out_count reads 1, having passed 15->0.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, in_ready=1, out_sum=0, out_count=0; no stale word appears afterward.
- Random masking: 1000 random (x, r) pairs driven as s0=x^r, s1=r -> every out_sum equals x and out_count=1000 mod 2^CNT_W.

Source files
------------

// File: rtl/masked_share_decoder.sv
`default_nettype none
// ============================================================================
// Module      : masked_share_decoder
// Description : Two-stage decoder for 2-share Boolean-masked sum/carry words.
//               Stage 1 registers each share separately (glitch barrier);
//               stage 2 XOR-recombines the registered shares into plaintext.
//               Valid/ready on both sides, one word per cycle, two-word
//               buffering under backpressure, and a completed-output counter.
// Revision    : 1.0 - initial release
// ============================================================================
module masked_share_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s0,
    input  logic [WIDTH-1:0] in_s1,
    input  logic             in_c0,
    input  logic             in_c1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    // Stage 1: one register per share, nothing combined before this point
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic             r_c0;
    logic             r_c1;
    logic             r_v1;

    // Stage 2: recombined plaintext
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_v2;

    logic [CNT_W-1:0] r_count;

    logic             w_adv2;
    logic             w_accept;
    logic             w_pop;

    // Stage 2 can take a word if it is empty or being drained this cycle;
    // in_ready deliberately ignores in_valid to avoid a combinational loop.
    always_comb begin
        w_adv2   = r_v1 && (!r_v2 || out_ready);
        in_ready = !r_v1 || w_adv2;
        w_accept = in_valid && in_ready;
        w_pop    = r_v2 && out_ready;
    end

    // Stage 1 share barrier: shares load only on an accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
            r_v1 <= 1'b0;
        end else if (w_accept) begin
            r_s0 <= in_s0;
            r_s1 <= in_s1;
            r_c0 <= in_c0;
            r_c1 <= in_c1;
            r_v1 <= 1'b1;
        end else if (w_adv2) begin
            r_v1 <= 1'b0;
        end
    end

    // Stage 2 recombination: the only place the two shares meet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_v2    <= 1'b0;
        end else if (w_adv2) begin
            r_sum   <= r_s0 ^ r_s1;
            r_carry <= r_c0 ^ r_c1;
            r_v2    <= 1'b1;
        end else if (out_ready) begin
            r_v2    <= 1'b0;
        end
    end

    // Completed-output counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign out_valid = r_v2;
    assign out_sum   = r_sum;
    assign out_carry = r_carry;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_masked_share_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_masked_share_decoder
// Description : Directed self-checking bench for masked_share_decoder.
//               A second instance with a 4-bit counter exercises the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_share_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_s0;
    logic [7:0] in_s1;
    logic       in_c0;
    logic       in_c1;
    logic       out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_sum;
    logic        out_carry;
    logic [15:0] out_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [7:0]  out_sum4;
    logic        out_carry4;
    logic [3:0]  out_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    masked_share_decoder #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_c0     (in_c0),
        .in_c1     (in_c1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    masked_share_decoder #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_c0     (in_c0),
        .in_c1     (in_c1),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_sum   (out_sum4),
        .out_carry (out_carry4),
        .out_count (out_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] exp_w;
        logic [7:0] x;
        logic [7:0] r;
        logic       c0;
        logic       c1;
        logic [3:0] carry_exp;
        logic [7:0] exp_out;
        logic       acc;
        int         acc_n;
        int         pops;
        int         cyc;

        // ---------------- reset ----------------
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = 8'h00; in_s1 = 8'h00; in_c0 = 1'b0; in_c1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_sum", out_sum, 8'h00);
        chk("rst_out_carry", out_carry, 1'b0);
        chk("rst_out_count", out_count, 16'd0);

        // ---------------- single word ----------------
        in_valid = 1'b1; in_s0 = 8'hA5; in_s1 = 8'h3C; in_c0 = 1'b1; in_c1 = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_s0 = 8'hFF; in_s1 = 8'h00;
        chk("single_lat1_valid", out_valid, 1'b0);
        tick();
        chk("single_valid", out_valid, 1'b1);
        chk("single_sum", out_sum, 8'h99);
        chk("single_carry", out_carry, 1'b1);
        chk("single_count0", out_count, 16'd0);
        tick();
        chk("single_count1", out_count, 16'd1);
        chk("single_drained", out_valid, 1'b0);

        // ---------------- carry truth table ----------------
        carry_exp = 4'b0110;  // bit k = expected carry of word k
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_s0 = 8'(k); in_s1 = 8'h00;
            in_c0 = k[1]; in_c1 = k[0];
            tick();
            chk("carry_in_ready", in_ready, 1'b1);
            if (k >= 1) begin
                chk("carry_valid", out_valid, 1'b1);
                chk("carry_val", out_carry, carry_exp[k-1]);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("carry_val_last", out_carry, carry_exp[3]);
        tick();
        chk("carry_count", out_count, 16'd5);
        chk("carry_drained", out_valid, 1'b0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0; in_c0 = 1'b0; in_c1 = 1'b0;
        in_valid = 1'b1; in_s0 = 8'h01; in_s1 = 8'h00;
        tick();
        chk("bp_ready_after1", in_ready, 1'b1);
        in_s0 = 8'h02;
        tick();
        chk("bp_ready_full", in_ready, 1'b0);
        chk("bp_hold_sum", out_sum, 8'h01);
        in_s0 = 8'h03;
        tick();
        chk("bp_ready_full2", in_ready, 1'b0);
        chk("bp_hold_sum2", out_sum, 8'h01);
        tick();
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_sum3", out_sum, 8'h01);
        out_ready = 1'b1;
        #1;
        chk("bp_pushpop_ready", in_ready, 1'b1);
        exp_out = 8'h01;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                chk("bp_order", out_sum, exp_out);
                exp_out++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (in_s0 == 8'h05) in_valid = 1'b0;
                else in_s0 = in_s0 + 8'h01;
            end
        end
        chk("bp_all_out", exp_out, 8'h06);
        chk("bp_count", out_count, 16'd10);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_s0 = 8'h55; in_s1 = 8'h00;
        tick();
        in_s0 = 8'h66;
        tick();
        in_valid = 1'b0;
        chk("mid_full_valid", out_valid, 1'b1);
        chk("mid_full_ready", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_sum", out_sum, 8'h00);
        chk("mid_rst_count", out_count, 16'd0);
        chk("mid_rst_count4", out_count4, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", out_valid, 1'b0);
        end

        // ---------------- counter wrap (4-bit instance) ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_s0 = 8'(i); in_s1 = 8'h00;
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_15", out_count4, 4'd15);
        tick();
        chk("wrap_0", out_count4, 4'd0);
        tick();
        chk("wrap_1", out_count4, 4'd1);
        chk("wrap_count16", out_count, 16'd17);

        // ---------------- random masking ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_n = 0; pops = 0; cyc = 0;
        in_valid = 1'b0;
        while ((acc_n < 1000 || pops < 1000) && cyc < 8000) begin
            if (!in_valid) begin
                in_s0 = 8'($urandom); in_s1 = 8'($urandom);
                in_c0 = 1'($urandom); in_c1 = 1'($urandom);
                if (acc_n < 1000 && $urandom_range(0, 4) != 0) begin
                    x = 8'($urandom); r = 8'($urandom);
                    c0 = 1'($urandom); c1 = 1'($urandom);
                    in_s0 = x ^ r; in_s1 = r; in_c0 = c0; in_c1 = c1;
                    in_valid = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_w = q.pop_front();
                    chk("rnd_sum", out_sum, exp_w[7:0]);
                    chk("rnd_carry", out_carry, exp_w[8]);
                end
                pops++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back({c0 ^ c1, x});
                acc_n++;
            end
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b1;
        chk("rnd_accepted", acc_n, 1000);
        chk("rnd_popped", pops, 1000);
        chk("rnd_count", out_count, 16'd1000);
        chk("rnd_count4", out_count4, 4'd8);
        chk("rnd_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
